button_input_controller: RTL and testbench

//   Input-side counterpart to the seven-segment output path: samples the board's raw

---
 rtl/button_input_controller.sv | 141 ++++++++++++++
 tb/tb_button_input_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : button_input_controller
// Description : Samples raw push-buttons and slide switches, synchronises and
//               debounces each one, keeps sticky press flags that the CPU
//               clears explicitly, and presents everything as a 32-bit word.
// Ports       :
//   clock_100mhz  in   1             system clock, rising edge
//   reset_n       in   1             asynchronous active-low reset
//   buttons_raw   in   NUM_BUTTONS   raw button pins, 1 = pressed
//   switches_raw  in   NUM_SWITCHES  raw switch pins, 1 = up
//   clear_strobe  in   1             clear sticky flags selected by clear_mask
//   clear_mask    in   NUM_BUTTONS   per-button clear select
//   input_word    out  32            {event, flags[6:0], buttons[7:0], switches[15:0]}
//   press_pulse   out  NUM_BUTTONS   one-cycle pulse per debounced press
//   event_pending out  1             OR of all sticky press flags
// Revision    : 1.0  initial release
// ============================================================================
module button_input_controller #(
  parameter int NUM_BUTTONS     = 5,
  parameter int NUM_SWITCHES    = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clock_100mhz,
  input  logic                    reset_n,
  input  logic [NUM_BUTTONS-1:0]  buttons_raw,
  input  logic [NUM_SWITCHES-1:0] switches_raw,
  input  logic                    clear_strobe,
  input  logic [NUM_BUTTONS-1:0]  clear_mask,
  output logic [31:0]             input_word,
  output logic [NUM_BUTTONS-1:0]  press_pulse,
  output logic                    event_pending
);

  localparam int N_IN = NUM_BUTTONS + NUM_SWITCHES;
  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The sample that moves the FSM out of IDLE is already the first of the
  // DEBOUNCE_CYCLES differing samples, so the change is accepted while the
  // counter holds DEBOUNCE_CYCLES-2, i.e. on the DEBOUNCE_CYCLES-th sample.
  // This gives a raw-step-to-stable latency of SYNC_STAGES+DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_t;

  // Buttons occupy the low bits, switches the high bits.
  logic [N_IN-1:0]        w_raw;
  logic [N_IN-1:0]        w_stable;
  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] r_pulse;
  logic [NUM_BUTTONS-1:0] r_sticky;
  logic [NUM_BUTTONS-1:0] w_clr;

  assign w_raw = {switches_raw, buttons_raw};

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_stable;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (r_state == COUNTING) && (w_sync != r_stable) &&
                      (r_cnt == c_cnt_last);

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
        r_sync   <= '0;
        r_stable <= 1'b0;
        r_state  <= IDLE;
        r_cnt    <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (w_sync != r_stable) begin
              r_state <= COUNTING;
            end
          end
          COUNTING: begin
            if (w_sync == r_stable) begin
              // Input bounced back before being confirmed.
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_cnt_last) begin
              r_stable <= w_sync;
              r_state  <= IDLE;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end

    assign w_stable[gi] = r_stable;

    if (gi < NUM_BUTTONS) begin : g_btn
      // Press detected on the same edge that the debounced level rises.
      assign w_rise[gi] = w_accept & w_sync;
    end
  end

  assign w_clr = clear_strobe ? clear_mask : '0;

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse  <= '0;
      r_sticky <= '0;
    end else begin
      r_pulse  <= w_rise;
      // A new press overrides a coincident clear.
      r_sticky <= (r_sticky & ~w_clr) | w_rise;
    end
  end

  assign press_pulse   = r_pulse;
  assign event_pending = |r_sticky;

  always_comb begin
    input_word        = '0;
    input_word[15:0]  = 16'(w_stable[N_IN-1:NUM_BUTTONS]);
    input_word[23:16] = 8'(w_stable[NUM_BUTTONS-1:0]);
    input_word[30:24] = 7'(r_sticky);
    input_word[31]    = |r_sticky;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_input_controller
// Description : Directed self-checking bench for button_input_controller with
//               DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 (6-edge accept latency).
// Revision    : 1.0  initial release
// ============================================================================
module tb_button_input_controller;

  logic        clk;
  logic        rst_n;
  logic [4:0]  buttons_raw;
  logic [15:0] switches_raw;
  logic        clear_strobe;
  logic [4:0]  clear_mask;
  logic [31:0] input_word;
  logic [4:0]  press_pulse;
  logic        event_pending;

  int n_total = 0;
  int n_bad   = 0;

  button_input_controller #(
    .NUM_BUTTONS    (5),
    .NUM_SWITCHES   (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clock_100mhz (clk),
    .reset_n      (rst_n),
    .buttons_raw  (buttons_raw),
    .switches_raw (switches_raw),
    .clear_strobe (clear_strobe),
    .clear_mask   (clear_mask),
    .input_word   (input_word),
    .press_pulse  (press_pulse),
    .event_pending(event_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    buttons_raw  = 5'h1F;
    switches_raw = 16'hFFFF;
    clear_strobe = 1'b0;
    clear_mask   = 5'h00;

    // 1: reset with all raw inputs high
    tick(3);
    check("rst_word", input_word, 32'h0);
    check("rst_pulse", {27'h0, press_pulse}, 32'h0);
    check("rst_event", {31'h0, event_pending}, 32'h0);
    buttons_raw  = 5'b00001;
    switches_raw = 16'h0000;
    rst_n        = 1'b1;
    tick(5);
    check("b0_before_edge6", input_word, 32'h0);
    tick(1);
    check("b0_word_edge6", input_word, 32'h8101_0000);
    check("b0_pulse", {27'h0, press_pulse}, 32'h1);
    tick(1);
    check("b0_pulse_gone", {27'h0, press_pulse}, 32'h0);
    clear_strobe = 1'b1;
    clear_mask   = 5'b00001;
    tick(1);
    clear_strobe = 1'b0;
    clear_mask   = 5'b00000;
    check("b0_cleared", input_word, 32'h0001_0000);

    // 2: 3-clock glitch on button 1
    buttons_raw[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) buttons_raw[1] = 1'b0;
      tick(1);
      check("glitch_level", {31'h0, input_word[17]}, 32'h0);
      check("glitch_pulse", {31'h0, press_pulse[1]}, 32'h0);
    end

    // 3: clean press and release of button 2
    buttons_raw[2] = 1'b1;
    tick(5);
    check("b2_pre", {31'h0, input_word[18]}, 32'h0);
    tick(1);
    check("b2_level", {31'h0, input_word[18]}, 32'h1);
    check("b2_pulse", {27'h0, press_pulse}, 32'h4);
    check("b2_flag", {31'h0, input_word[26]}, 32'h1);
    check("b2_event", {31'h0, input_word[31]}, 32'h1);
    tick(1);
    check("b2_pulse_once", {27'h0, press_pulse}, 32'h0);
    buttons_raw[2] = 1'b0;
    tick(5);
    check("b2_rel_pre", {31'h0, input_word[18]}, 32'h1);
    tick(1);
    check("b2_rel_level", {31'h0, input_word[18]}, 32'h0);
    check("b2_rel_flag", {31'h0, input_word[26]}, 32'h1);
    check("b2_rel_nopulse", {27'h0, press_pulse}, 32'h0);

    // 4: clear, then coincident press and clear
    clear_strobe = 1'b1;
    clear_mask   = 5'b00100;
    tick(1);
    clear_strobe = 1'b0;
    check("clr_flag", {31'h0, input_word[26]}, 32'h0);
    check("clr_event", {31'h0, input_word[31]}, 32'h0);
    buttons_raw[2] = 1'b1;
    tick(5);
    clear_strobe = 1'b1;
    tick(1);
    clear_strobe = 1'b0;
    check("setwin_pulse", {27'h0, press_pulse}, 32'h4);
    check("setwin_flag", {31'h0, input_word[26]}, 32'h1);
    clear_strobe = 1'b1;
    clear_mask   = 5'b00000;
    tick(1);
    clear_strobe = 1'b0;
    check("mask0_noeffect", input_word, 32'h8405_0000);

    // 5: switches
    switches_raw = 16'hA5C3;
    tick(5);
    check("sw_pre", {16'h0, input_word[15:0]}, 32'h0);
    tick(1);
    check("sw_value", {16'h0, input_word[15:0]}, 32'h0000_A5C3);
    check("sw_nopulse", {27'h0, press_pulse}, 32'h0);
    check("sw_event", {31'h0, event_pending}, 32'h1);

    // 6: reset in the middle of a debounce count on button 3
    buttons_raw[3] = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_word", input_word, 32'h0);
    check("midrst_pulse", {27'h0, press_pulse}, 32'h0);
    check("midrst_event", {31'h0, event_pending}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rerel_pre", input_word, 32'h0);
    tick(1);
    check("rerel_word", input_word, 32'h8D0D_A5C3);
    check("rerel_pulse", {27'h0, press_pulse}, 32'h0000_000D);
    tick(1);
    check("rerel_pulse_once", {27'h0, press_pulse}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
